// File: rtl/order_stream_gen.sv
// Multi-channel pseudo-random buy/sell price source: per-channel 16-bit Galois LFSRs
// stepped by a clock divider, delivered over valid/ready with overrun counting and reseed.
module order_stream_gen #(
    parameter int          CHANNELS   = 2,
    parameter int          PRICE_W    = 8,
    parameter int          BASE_PRICE = 50,
    parameter int          OFS_BITS   = 5,
    parameter int          MIN_SPREAD = 5,
    parameter int          DIV_MAX    = 50000000,
    parameter logic [15:0] SEED0      = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         key_n,
    input  logic                         enable,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [CHANNELS*PRICE_W-1:0]  buy_price,
    output logic [CHANNELS*PRICE_W-1:0]  sell_price,
    output logic [7:0]                   overrun_cnt,
    output logic                         tick
);

    localparam int                DIV_W  = $clog2(DIV_MAX);
    localparam int                CALC_W = PRICE_W + 2;
    localparam logic [CALC_W-1:0] SAT    = CALC_W'({PRICE_W{1'b1}});

    function automatic logic [15:0] zero_guard(input logic [15:0] v);
        return (v == 16'h0000) ? 16'h0001 : v;
    endfunction

    function automatic logic [15:0] seed_of(input int k);
        return zero_guard((SEED0 << k) | (SEED0 >> (16 - k)));
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [PRICE_W-1:0] saturate(input logic [CALC_W-1:0] v);
        return (v > SAT) ? {PRICE_W{1'b1}} : v[PRICE_W-1:0];
    endfunction

    logic [DIV_W-1:0]            div_q, div_d;
    logic [15:0]                 lfsr_q [CHANNELS];
    logic [15:0]                 lfsr_d [CHANNELS];
    logic [2:0]                  key_sync_q;
    logic                        load_pend_q;
    logic                        out_valid_q, out_valid_d;
    logic [CHANNELS*PRICE_W-1:0] buy_q, buy_d, sell_q, sell_d;
    logic [CHANNELS*PRICE_W-1:0] buy_calc, sell_calc;
    logic [7:0]                  overrun_q, overrun_d;
    logic                        reseed;
    logic                        load;

    assign tick   = enable && (div_q == DIV_W'(DIV_MAX - 1));
    // key_sync_q[1] is the synchronised button, key_sync_q[2] its previous value.
    assign reseed = key_sync_q[2] & ~key_sync_q[1];
    assign load   = load_pend_q && (!out_valid_q || out_ready);

    always_comb begin
        logic [7:0]        div_bits;
        logic [CALC_W-1:0] buy_raw, sell_raw;
        // NOTE: every combinational output gets a default first so no path infers a latch.
        div_d     = div_q;
        buy_calc  = '0;
        sell_calc = '0;
        if (enable) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end
        for (int k = 0; k < CHANNELS; k++) begin
            lfsr_d[k] = lfsr_q[k];
            for (int i = 0; i < 8; i++) begin
                div_bits[i] = div_q[(8 * k + i) % DIV_W];
            end
            if (enable && reseed) begin
                lfsr_d[k] = zero_guard({lfsr_q[k][7:0], div_bits});
            end else if (tick) begin
                lfsr_d[k] = lfsr_step(lfsr_q[k]);
            end
            buy_raw  = CALC_W'(BASE_PRICE) + CALC_W'(lfsr_q[k][OFS_BITS-1:0]);
            sell_raw = buy_raw + CALC_W'(MIN_SPREAD) + CALC_W'(lfsr_q[k][8+OFS_BITS-1:8]);
            buy_calc[k*PRICE_W +: PRICE_W]  = saturate(buy_raw);
            sell_calc[k*PRICE_W +: PRICE_W] = saturate(sell_raw);
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        buy_d       = buy_q;
        sell_d      = sell_q;
        overrun_d   = overrun_q;
        if (load) begin
            out_valid_d = 1'b1;
            buy_d       = buy_calc;
            sell_d      = sell_calc;
        end else if (load_pend_q) begin
            if (overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q       <= '0;
            key_sync_q  <= 3'b111;
            load_pend_q <= 1'b0;
            out_valid_q <= 1'b0;
            buy_q       <= '0;
            sell_q      <= '0;
            overrun_q   <= '0;
            for (int k = 0; k < CHANNELS; k++) lfsr_q[k] <= seed_of(k);
        end else begin
            div_q       <= div_d;
            key_sync_q  <= {key_sync_q[1:0], key_n};
            load_pend_q <= tick;
            out_valid_q <= out_valid_d;
            buy_q       <= buy_d;
            sell_q      <= sell_d;
            overrun_q   <= overrun_d;
            for (int k = 0; k < CHANNELS; k++) lfsr_q[k] <= lfsr_d[k];
        end
    end

    assign out_valid   = out_valid_q;
    assign buy_price   = buy_q;
    assign sell_price  = sell_q;
    assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_order_stream_gen.sv
// Directed bench for order_stream_gen: two instances (default prices and a saturating
// BASE_PRICE=250 variant) sharing stimulus, DIV_MAX=4, expected prices derived by hand.
module tb_order_stream_gen;

    logic        clk;
    logic        reset;
    logic        key_n;
    logic        enable;
    logic        out_ready;
    logic        out_valid,   sat_valid;
    logic [15:0] buy_price,   sat_buy;
    logic [15:0] sell_price,  sat_sell;
    logic [7:0]  overrun_cnt, sat_overrun;
    logic        tick,        sat_tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    order_stream_gen #(.DIV_MAX(4)) dut (
        .clk(clk), .reset(reset), .key_n(key_n), .enable(enable), .out_ready(out_ready),
        .out_valid(out_valid), .buy_price(buy_price), .sell_price(sell_price),
        .overrun_cnt(overrun_cnt), .tick(tick)
    );

    order_stream_gen #(.DIV_MAX(4), .BASE_PRICE(250)) dut_sat (
        .clk(clk), .reset(reset), .key_n(key_n), .enable(enable), .out_ready(out_ready),
        .out_valid(sat_valid), .buy_price(sat_buy), .sell_price(sat_sell),
        .overrun_cnt(sat_overrun), .tick(sat_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to the falling edge that follows rising edge number 'target' since reset release.
    task automatic goto(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    function automatic logic [31:0] pk(input int ch1, input int ch0);
        logic [7:0] a;
        logic [7:0] b;
        a = ch1[7:0];
        b = ch0[7:0];
        return {16'h0, a, b};
    endfunction

    initial begin
        reset = 1'b1; key_n = 1'b1; enable = 1'b1; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_buy", buy_price, 0);
        check("rst_sell", sell_price, 0);
        check("rst_overrun", overrun_cnt, 0);
        check("rst_tick", tick, 0);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;

        // first sample: tick in cycle 3, visible after edge 5
        goto(2);  check("tick_pre", tick, 0);
        goto(3);  check("tick_first", tick, 1);
        goto(4);  check("valid_latency", out_valid, 0);
        goto(5);
        check("s1_valid", out_valid, 1);
        check("s1_buy", buy_price, pk(51, 66));
        check("s1_sell", sell_price, pk(80, 73));
        check("sat_s1_buy", sat_buy, pk(251, 255));
        check("sat_s1_sell", sat_sell, pk(255, 255));
        goto(6);  check("s1_accepted", out_valid, 0);
        out_ready = 1'b0;

        // backpressure: s2 held, s3 and s4 dropped
        goto(9);
        check("s2_valid", out_valid, 1);
        check("s2_buy", buy_price, pk(66, 74));
        check("s2_sell", sell_price, pk(95, 96));
        goto(13);
        check("ovr_1", overrun_cnt, 1);
        check("s2_hold_buy", buy_price, pk(66, 74));
        goto(17);
        check("ovr_2", overrun_cnt, 2);
        check("s2_hold_valid", out_valid, 1);
        check("s2_hold_sell", sell_price, pk(95, 96));
        out_ready = 1'b1;
        goto(18); check("s2_accepted", out_valid, 0);
        goto(21);
        check("s5_valid", out_valid, 1);
        check("s5_buy", buy_price, pk(64, 57));
        check("s5_sell", sell_price, pk(100, 76));
        check("sat_s5_buy", sat_buy, pk(255, 255));

        // reseed pulse lands on the tick cycle 23-24
        key_n = 1'b0;
        goto(23); check("tick_reseed", tick, 1);
        goto(24); key_n = 1'b1;
        goto(25);
        check("reseed_valid", out_valid, 1);
        check("reseed_buy", buy_price, pk(81, 81));
        check("reseed_sell", sell_price, pk(100, 93));
        goto(29);
        check("after_reseed_buy", buy_price, pk(81, 81));
        check("after_reseed_sell", sell_price, pk(105, 93));

        // one-cycle glitch: reseed at edge 33 with div=0
        goto(30); key_n = 1'b0;
        goto(31); key_n = 1'b1;
        goto(33);
        check("pre_glitch_buy", buy_price, pk(81, 81));
        check("pre_glitch_sell", sell_price, pk(99, 93));

        // disable right after the tick edge: pending load still completes
        goto(36); enable = 1'b0;
        goto(37);
        check("glitch_valid", out_valid, 1);
        check("glitch_buy", buy_price, pk(50, 50));
        check("glitch_sell", sell_price, pk(86, 86));
        check("sat_base_buy", sat_buy, pk(250, 250));
        check("sat_base_sell", sat_sell, pk(255, 255));
        goto(38); check("disabled_accept", out_valid, 0);
        while (cyc < 57) begin
            goto(cyc + 1);
            check("disabled_tick", tick, 0);
        end
        enable = 1'b1;
        goto(59); check("resume_no_tick", tick, 0);
        goto(60); check("resume_tick", tick, 1);
        goto(62);
        check("resume_buy", buy_price, pk(50, 50));
        check("resume_sell", sell_price, pk(70, 86));
        out_ready = 1'b0;

        // reset while a sample is held and another load is pending
        goto(65);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_ovr", overrun_cnt, 2);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_buy", buy_price, 0);
        check("mid_rst_sell", sell_price, 0);
        check("mid_rst_ovr", overrun_cnt, 0);
        check("mid_rst_tick", tick, 0);
        check("mid_rst_sat_buy", sat_buy, 0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        goto(4); check("post_rst_latency", out_valid, 0);
        goto(5);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_buy", buy_price, pk(51, 66));
        check("post_rst_sell", sell_price, pk(80, 73));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
